// File: rtl/ins_pkg.sv
// Shared widths, reset vector and fetch-state encoding for the instruction fetch unit.
package ins_pkg;
  localparam int PC_W        = 11;
  localparam int INSTR_W     = 12;
  localparam int STACK_DEPTH = 8;
  localparam logic [PC_W-1:0] RESET_VEC = 11'd0;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_e;

  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + 11'd1;
  endfunction
endpackage

// File: rtl/ins_call_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// a pop when empty leaves the stack untouched (the caller flags and handles it).
module ins_call_stack
  import ins_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH,
  parameter int W     = PC_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q;   // next free slot; once full it also marks the oldest entry
  logic [CNT_W-1:0] cnt_q;
  logic [PTR_W-1:0] top_s;

  assign top_s   = ptr_q - PTR_ONE;
  assign data_o  = mem_q[top_s];
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == CNT_W'(0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i) begin
      mem_q[ptr_q] <= data_i;
      ptr_q        <= ptr_q + PTR_ONE;
      if (!full_o) cnt_q <= cnt_q + CNT_ONE;
    end else if (pop_i && !empty_o) begin
      ptr_q <= top_s;
      cnt_q <= cnt_q - CNT_ONE;
    end
  end
endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch unit: PC, boot/run/halt FSM, one-entry registered output stage,
// and redirect/call/return handling through the call stack.
module ins_fetch
  import ins_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    instr_pc_o,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  input  logic               redirect_i,
  input  logic               call_i,
  input  logic               ret_i,
  input  logic [PC_W-1:0]    target_i,
  input  logic [PC_W-1:0]    ret_addr_i,
  input  logic               halt_i,
  output logic               stack_ovf_o,
  output logic               stack_unf_o,
  output logic               ctrl_err_o
);
  fetch_state_e       state_q;
  logic [PC_W-1:0]    pc_q, ipc_q, new_pc_s, stk_top_s;
  logic [INSTR_W-1:0] instr_q;
  logic               valid_q, ovf_q, unf_q, err_q;
  logic               ctrl_s, multi_s, push_s, pop_s, load_s, full_s, empty_s;

  assign rom_addr      = pc_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = ipc_q;
  assign instr_valid_o = valid_q;
  assign stack_ovf_o   = ovf_q;
  assign stack_unf_o   = unf_q;
  assign ctrl_err_o    = err_q;

  ins_call_stack #(.DEPTH(STACK_DEPTH), .W(PC_W)) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .data_i  (ret_addr_i),
    .data_o  (stk_top_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Control-event priority (ret > call > redirect) and the load decision.
  always_comb begin
    ctrl_s  = redirect_i | call_i | ret_i;
    multi_s = (redirect_i & call_i) | (redirect_i & ret_i) | (call_i & ret_i);
    pop_s   = ret_i;
    push_s  = call_i & ~ret_i;
    if (ret_i) begin
      new_pc_s = empty_s ? RESET_VEC : stk_top_s;
    end else begin
      new_pc_s = target_i;
    end
    load_s = (state_q == S_RUN) && !halt_i && !ctrl_s && (!valid_q || instr_ready_i);
  end

  // FSM, PC, output stage and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VEC;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (multi_s)           err_q <= 1'b1;
      if (push_s && full_s)  ovf_q <= 1'b1;
      if (pop_s && empty_s)  unf_q <= 1'b1;

      if (ctrl_s) begin
        pc_q    <= new_pc_s;
        valid_q <= 1'b0;
      end else if (load_s) begin
        instr_q <= rom_data;
        ipc_q   <= pc_q;
        valid_q <= 1'b1;
        pc_q    <= pc_inc(pc_q);
      end else if (valid_q && instr_ready_i) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        S_BOOT:  state_q <= S_RUN;
        S_RUN:   if (!ctrl_s && halt_i)  state_q <= S_HALT;
        S_HALT:  if (!ctrl_s && !halt_i) state_q <= S_RUN;
        default: state_q <= S_BOOT;
      endcase
    end
  end
endmodule

// File: tb/tb_ins_fetch.sv
// Randomized bench for ins_fetch checked every cycle against a queue-based behavioural model.
module tb_ins_fetch;
  import ins_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [PC_W-1:0]    rom_addr;
  logic [INSTR_W-1:0] rom_data;
  logic [INSTR_W-1:0] instr_o;
  logic [PC_W-1:0]    instr_pc_o;
  logic               instr_valid_o;
  logic               instr_ready_i = 1'b0;
  logic               redirect_i = 1'b0, call_i = 1'b0, ret_i = 1'b0, halt_i = 1'b0;
  logic [PC_W-1:0]    target_i = '0, ret_addr_i = '0;
  logic               stack_ovf_o, stack_unf_o, ctrl_err_o;

  int n_cmp = 0;
  int n_err = 0;

  ins_fetch dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i), .redirect_i(redirect_i), .call_i(call_i), .ret_i(ret_i),
    .target_i(target_i), .ret_addr_i(ret_addr_i), .halt_i(halt_i),
    .stack_ovf_o(stack_ovf_o), .stack_unf_o(stack_unf_o), .ctrl_err_o(ctrl_err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_fn(input int a);
    int v;
    v = ((a * 37) + 5) ^ 32'h5A5;
    return v[11:0];
  endfunction

  assign rom_data = rom_fn(int'(rom_addr));

  // Behavioural model: program counter, output word, and the call stack as a queue.
  int  m_pc, m_instr, m_ipc;
  bit  m_valid, m_ovf, m_unf, m_err, m_booting, m_halted;
  int  stk[$];

  task automatic model_reset();
    m_pc = 0; m_instr = 0; m_ipc = 0; m_valid = 0;
    m_ovf = 0; m_unf = 0; m_err = 0; m_booting = 1; m_halted = 0;
    stk.delete();
  endtask

  task automatic model_step();
    int nctl;
    nctl = int'(redirect_i) + int'(call_i) + int'(ret_i);
    if (nctl > 0) begin
      if (nctl > 1) m_err = 1;
      if (ret_i) begin
        if (stk.size() == 0) begin m_unf = 1; m_pc = 0; end
        else m_pc = stk.pop_back();
      end else if (call_i) begin
        stk.push_back(int'(ret_addr_i));
        if (stk.size() > STACK_DEPTH) begin void'(stk.pop_front()); m_ovf = 1; end
        m_pc = int'(target_i);
      end else begin
        m_pc = int'(target_i);
      end
      m_valid = 0;
    end else if (!m_booting && !m_halted && !halt_i && (!m_valid || instr_ready_i)) begin
      m_instr = int'(rom_fn(m_pc));
      m_ipc   = m_pc;
      m_valid = 1;
      m_pc    = (m_pc + 1) % 2048;
    end else if (m_valid && instr_ready_i) begin
      m_valid = 0;
    end
    if (m_booting) m_booting = 0;
    else if (m_halted) begin if (nctl == 0 && !halt_i) m_halted = 0; end
    else if (nctl == 0 && halt_i) m_halted = 1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    chk("rom_addr", rom_addr, m_pc);
    chk("valid", instr_valid_o, m_valid);
    if (m_valid) begin
      chk("instr", instr_o, m_instr);
      chk("instr_pc", instr_pc_o, m_ipc);
    end
    chk("ovf", stack_ovf_o, m_ovf);
    chk("unf", stack_unf_o, m_unf);
    chk("err", ctrl_err_o, m_err);
  endtask

  task automatic drive(input bit rdy, input bit rd, input bit cl, input bit rt,
                       input int tg, input int ra, input bit hl);
    instr_ready_i = rdy; redirect_i = rd; call_i = cl; ret_i = rt;
    target_i = PC_W'(tg); ret_addr_i = PC_W'(ra); halt_i = hl;
  endtask

  task automatic step();
    @(negedge clk);
    cmp_all();
  endtask

  task automatic wait_ipc(input int pc);
    int k;
    k = 0;
    while (!(instr_valid_o === 1'b1 && instr_pc_o == PC_W'(pc)) && k < 3000) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      step();
      k++;
    end
    chk("wait_ipc_bound", k < 3000, 1);
  endtask

  initial begin
    model_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (2) step();
    chk("rst_valid", instr_valid_o, 0);
    chk("rst_addr", rom_addr, 0);
    rst_n = 1'b1;
    step(); chk("boot_valid", instr_valid_o, 0);
    step(); chk("first_valid", instr_valid_o, 1); chk("first_pc", instr_pc_o, 0); chk("first_addr", rom_addr, 1);
    step(); chk("second_pc", instr_pc_o, 1); chk("second_instr", instr_o, 12'h58F);

    wait_ipc(5);
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
    chk("bp_pc", instr_pc_o, 5); chk("bp_instr", instr_o, 12'h51B); chk("bp_addr", rom_addr, 6);
    drive(1, 0, 0, 0, 0, 0, 0);
    step(); chk("bp_resume6", instr_pc_o, 6);
    step(); chk("bp_resume7", instr_pc_o, 7);

    wait_ipc(10);
    drive(0, 0, 0, 0, 0, 0, 0); step(); chk("rd_held", instr_pc_o, 10);
    drive(0, 1, 0, 0, 32'h20, 0, 0); step();
    chk("rd_flush", instr_valid_o, 0); chk("rd_addr", rom_addr, 11'h20);
    drive(1, 0, 0, 0, 0, 0, 0);
    step(); chk("rd_pc20", instr_pc_o, 11'h20);
    step(); chk("rd_pc21", instr_pc_o, 11'h21);

    drive(1, 0, 1, 0, 32'h40, 32'h11, 0); step(); chk("call_addr", rom_addr, 11'h40);
    drive(1, 0, 0, 0, 0, 0, 0);
    step(); chk("call_pc40", instr_pc_o, 11'h40);
    step(); chk("call_pc41", instr_pc_o, 11'h41);
    drive(1, 0, 0, 1, 0, 0, 0); step(); chk("ret_addr", rom_addr, 11'h11);
    drive(1, 0, 0, 0, 0, 0, 0); step(); chk("ret_pc", instr_pc_o, 11'h11);

    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 1, 0, 32'h100 + i, 32'h200 + i, 0);
      step();
    end
    chk("nest_ovf", stack_ovf_o, 1);
    drive(1, 0, 0, 1, 0, 0, 0); step(); chk("pop_top", rom_addr, 11'h208);
    repeat (7) step();
    chk("pop_last", rom_addr, 11'h201); chk("pop_no_unf", stack_unf_o, 0);
    step(); chk("unf_addr", rom_addr, 0); chk("unf_flag", stack_unf_o, 1);

    drive(1, 1, 1, 0, 32'h300, 32'h123, 0); step();
    chk("err_flag", ctrl_err_o, 1); chk("err_addr", rom_addr, 11'h300);
    drive(1, 0, 0, 1, 0, 0, 0); step(); chk("err_call_won", rom_addr, 11'h123);

    drive(1, 1, 0, 0, 32'h7FE, 0, 0); step();
    wait_ipc(32'h7FF); chk("wrap_addr", rom_addr, 0);
    step(); chk("wrap_pc", instr_pc_o, 0);

    drive(1, 0, 0, 0, 0, 0, 1); step(); step(); chk("halt_drained", instr_valid_o, 0);
    drive(1, 1, 0, 0, 32'h50, 0, 1); step(); chk("halt_rd_addr", rom_addr, 11'h50);
    drive(1, 0, 0, 0, 0, 0, 1); step(); chk("halt_no_load", instr_valid_o, 0);
    drive(1, 0, 0, 0, 0, 0, 0); step(); step(); chk("halt_resume", instr_pc_o, 11'h50);

    begin
      bit hl;
      hl = 0;
      for (int c = 0; c < 1500; c++) begin
        int r;
        r = int'($urandom_range(99));
        if ($urandom_range(99) < 4) hl = ~hl;
        if (r == 99)
          drive($urandom_range(3) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(2047)), int'($urandom_range(2047)), hl);
        else
          drive($urandom_range(3) != 0, r < 3, r >= 3 && r < 7, r >= 7 && r < 10,
                int'($urandom_range(2047)), int'($urandom_range(2047)), hl);
        step();
      end
    end

    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", instr_valid_o, 0); chk("mrst_instr", instr_o, 0);
    chk("mrst_ipc", instr_pc_o, 0); chk("mrst_addr", rom_addr, 0);
    chk("mrst_flags", {stack_ovf_o, stack_unf_o, ctrl_err_o}, 0);
    step();
    drive(1, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step(); step();
    chk("mrst_restart_valid", instr_valid_o, 1); chk("mrst_restart_pc", instr_pc_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
